// File: rtl/l2_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_wbuf_pkg
// Description : Shared types and constants for the L2 write-through buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_wbuf_pkg;

  // Byte-offset bits dropped to form a word address.
  localparam int WORD_OFF = 2;

  // One buffered store: valid flag, word address [31:2], data word.
  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  // Drain state: IDLE (nothing presented) or REQ (head presented to L2).
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wbuf_state_e;

endpackage
`default_nettype wire

// File: rtl/wbuf_addr_match.sv
`default_nettype none
// ============================================================================
// Module      : wbuf_addr_match
// Description : DEPTH-way comparator array. Yields a one-hot word match for
//               store merging (excluding the in-flight head) and a line-match
//               flag for read-miss conflict detection.
// Revision    : 1.0 - initial release
// ============================================================================
module wbuf_addr_match
  import l2_wbuf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_OFF = 5,
  parameter int IDXW     = $clog2(DEPTH)
) (
  input  wbuf_entry_t [DEPTH-1:0] i_entries,
  input  logic [IDXW-1:0]         i_head_idx,
  input  logic                    i_in_flight,
  input  logic [29:0]             i_wr_waddr,
  input  logic [31:0]             i_rd_addr,
  output logic [DEPTH-1:0]        o_word_match,
  output logic                    o_line_match
);

  logic [DEPTH-1:0] w_line_hit;
  logic             w_unused;

  // Byte offsets within a line never take part in the line compare.
  assign w_unused = ^i_rd_addr[LINE_OFF-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic w_is_flight_head;
      // The head being written to L2 must not absorb new data.
      assign w_is_flight_head = i_in_flight && (i_head_idx == IDXW'(gi));
      assign o_word_match[gi] = i_entries[gi].valid && !w_is_flight_head &&
                                (i_entries[gi].addr == i_wr_waddr);
      assign w_line_hit[gi]   = i_entries[gi].valid &&
                                (i_entries[gi].addr[29:LINE_OFF-WORD_OFF] ==
                                 i_rd_addr[31:LINE_OFF]);
    end
  endgenerate

  assign o_line_match = |w_line_hit;

endmodule
`default_nettype wire

// File: rtl/l2_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : l2_write_buffer
// Description : Write-through store buffer between L1 and L2. Queues word
//               stores in a circular FIFO, merges repeated stores to the same
//               word, drains to L2 with req/ack and flags read-miss conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_write_buffer
  import l2_wbuf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_OFF = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [31:0]            wr_addr,
  input  logic [31:0]            wr_data,
  output logic                   wr_ready,
  input  logic [31:0]            rd_chk_addr,
  output logic                   rd_chk_conflict,
  output logic                   l2_wr_req,
  output logic [31:0]            l2_wr_addr,
  output logic [31:0]            l2_wr_data,
  input  logic                   l2_wr_ack,
  output logic                   buf_empty,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int PW   = IDXW + 1;

  wbuf_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  wbuf_state_e             r_state;
  logic                    r_req;
  logic [29:0]             r_out_waddr;
  logic [31:0]             r_out_data;
  logic [PW-1:0]           r_count;
  logic                    r_empty;

  logic [IDXW-1:0]  w_head_idx;
  logic [IDXW-1:0]  w_tail_idx;
  logic [PW-1:0]    w_head_inc;
  logic [PW-1:0]    w_head_nxt;
  logic [PW-1:0]    w_tail_nxt;
  logic [PW-1:0]    w_count_nxt;
  logic             w_full;
  logic             w_ptr_empty;
  logic             w_in_flight;
  logic             w_others;
  logic [29:0]      w_wr_waddr;
  logic [DEPTH-1:0] w_word_match;
  logic             w_line_match;
  logic             w_accept;
  logic             w_merge;
  logic             w_push;
  logic             w_pop;
  logic [IDXW-1:0]  w_load_idx;
  logic [31:0]      w_load_data;
  logic             w_state_nxt_req;
  logic             w_unused;

  // Byte lane bits of the store address are irrelevant to a word buffer.
  assign w_unused    = ^wr_addr[WORD_OFF-1:0];

  assign w_head_idx  = r_head[IDXW-1:0];
  assign w_tail_idx  = r_tail[IDXW-1:0];
  assign w_head_inc  = r_head + PW'(1);
  assign w_full      = (w_head_idx == w_tail_idx) && (r_head[IDXW] != r_tail[IDXW]);
  assign w_ptr_empty = (r_head == r_tail);
  assign w_in_flight = (r_state == REQ);
  assign w_others    = (w_head_inc != r_tail);
  assign w_wr_waddr  = wr_addr[31:WORD_OFF];

  wbuf_addr_match #(
    .DEPTH    (DEPTH),
    .LINE_OFF (LINE_OFF),
    .IDXW     (IDXW)
  ) u_match (
    .i_entries    (r_mem),
    .i_head_idx   (w_head_idx),
    .i_in_flight  (w_in_flight),
    .i_wr_waddr   (w_wr_waddr),
    .i_rd_addr    (rd_chk_addr),
    .o_word_match (w_word_match),
    .o_line_match (w_line_match)
  );

  // No push-through when full: a pop in the same cycle does not open a slot.
  assign wr_ready    = !w_full;
  assign w_accept    = wr_valid && wr_ready;
  assign w_merge     = w_accept && (|w_word_match);
  assign w_push      = w_accept && !w_merge;
  assign w_pop       = w_in_flight && l2_wr_ack;

  assign w_tail_nxt  = w_push ? (r_tail + PW'(1)) : r_tail;
  assign w_head_nxt  = w_pop ? w_head_inc : r_head;
  assign w_count_nxt = w_tail_nxt - w_head_nxt;

  // Entry to present next: current head from IDLE, successor after an ack.
  // A merge landing on that entry this cycle is forwarded so L2 sees it.
  assign w_load_idx  = w_in_flight ? w_head_inc[IDXW-1:0] : w_head_idx;
  assign w_load_data = (w_merge && w_word_match[w_load_idx]) ? wr_data
                                                              : r_mem[w_load_idx].data;

  // Whether the drain FSM will be in REQ after this edge (feeds buf_empty).
  assign w_state_nxt_req = w_in_flight ? !(l2_wr_ack && !w_others) : !w_ptr_empty;

  assign rd_chk_conflict = w_line_match;
  assign l2_wr_req       = r_req;
  assign l2_wr_addr      = {r_out_waddr, {WORD_OFF{1'b0}}};
  assign l2_wr_data      = r_out_data;
  assign buf_empty       = r_empty;
  assign buf_count       = r_count;

  // Entry storage: allocate at tail, merge in place, invalidate head on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_merge && w_word_match[i]) begin
          r_mem[i].data <= wr_data;
        end
      end
      if (w_push) begin
        r_mem[w_tail_idx] <= {1'b1, w_wr_waddr, wr_data};
      end
      if (w_pop) begin
        r_mem[w_head_idx].valid <= 1'b0;
      end
    end
  end

  // Pointers and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0) && !w_state_nxt_req;
    end
  end

  // Drain FSM with registered L2 request, address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_out_waddr <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_ptr_empty) begin
            r_state     <= REQ;
            r_req       <= 1'b1;
            r_out_waddr <= r_mem[w_load_idx].addr;
            r_out_data  <= w_load_data;
          end
        end
        REQ: begin
          if (l2_wr_ack) begin
            if (w_others) begin
              r_out_waddr <= r_mem[w_load_idx].addr;
              r_out_data  <= w_load_data;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_write_buffer
// Description : Self-checking bench for l2_write_buffer. A queue-based model
//               tracks buffered stores; completed L2 writes go to a
//               scoreboard consumed by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_write_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [31:0] rd_chk_addr;
  logic        rd_chk_conflict;
  logic        l2_wr_req;
  logic [31:0] l2_wr_addr;
  logic [31:0] l2_wr_data;
  logic        l2_wr_ack;
  logic        buf_empty;
  logic [2:0]  buf_count;

  l2_write_buffer #(.DEPTH(DEPTH), .LINE_OFF(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .rd_chk_addr     (rd_chk_addr),
    .rd_chk_conflict (rd_chk_conflict),
    .l2_wr_req       (l2_wr_req),
    .l2_wr_addr      (l2_wr_addr),
    .l2_wr_data      (l2_wr_data),
    .l2_wr_ack       (l2_wr_ack),
    .buf_empty       (buf_empty),
    .buf_count       (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;   // word-aligned byte address
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];     // model: buffered stores, oldest first
  bit          mfl;       // model: oldest store is being offered to L2
  bit          mrst_prev;
  ent_t        sb[$];     // expected L2 writes, in order
  int          errors = 0;
  int          checks = 0;
  logic [31:0] g_ra = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mconf(input logic [31:0] ra);
    for (int i = 0; i < mq.size(); i++)
      if ((mq[i].a >> 5) == (ra >> 5)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: check registered state, drive inputs, check
  // combinational outputs, then advance the model past the coming edge.
  task automatic cyc(input bit r, input bit v, input logic [31:0] a,
                     input logic [31:0] d, input bit k, input logic [31:0] ra);
    int pre;
    bit pop;
    int hit;
    logic [31:0] wa;
    @(negedge clk);
    chk("l2_wr_req", {31'b0, l2_wr_req}, {31'b0, mfl});
    chk("buf_count", {29'b0, buf_count}, mq.size());
    chk("buf_empty", {31'b0, buf_empty}, {31'b0, (mq.size() == 0) && !mfl});
    if (mrst_prev) begin
      chk("l2_wr_addr_rst", l2_wr_addr, 32'h0);
      chk("l2_wr_data_rst", l2_wr_data, 32'h0);
    end
    rst = r; wr_valid = v; wr_addr = a; wr_data = d; l2_wr_ack = k; rd_chk_addr = ra;
    #1;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, mq.size() < DEPTH});
    chk("rd_chk_conflict", {31'b0, rd_chk_conflict}, {31'b0, mconf(ra)});
    mrst_prev = r;
    if (r) begin
      mq.delete();
      mfl = 1'b0;
    end else begin
      pre = mq.size();
      pop = mfl && k;
      hit = -1;
      wa  = {a[31:2], 2'b00};
      if (pop) sb.push_back(mq[0]);
      if (v && pre < DEPTH) begin
        for (int i = 0; i < pre; i++)
          if (mq[i].a == wa && !(mfl && i == 0)) hit = i;
        if (hit >= 0) mq[hit].d = d;
        else          mq.push_back('{wa, d});
      end
      if (pop) void'(mq.pop_front());
      mfl = mfl ? (pop ? (pre > 1) : 1'b1) : (pre > 0);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, g_ra);
  endtask

  task automatic idle(input int n, input bit k);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, k, g_ra);
  endtask

  // Monitor: every accepted L2 write must match the next expected write.
  always @(negedge clk) begin
    ent_t e;
    #2;
    if (l2_wr_req && l2_wr_ack && !rst) begin
      if (sb.size() == 0) begin
        chk("l2_unexpected_write", l2_wr_addr, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("l2_wr_addr", l2_wr_addr, e.a);
        chk("l2_wr_data", l2_wr_data, e.d);
      end
    end
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    l2_wr_ack = 1'b0; rd_chk_addr = '0;
    mfl = 1'b0; mrst_prev = 1'b1;

    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    idle(1, 1'b1);                         // ack in IDLE is ignored

    // Single store then drain
    st(32'h1000, 32'hDEAD_BEEF);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Fill, backpressure, in-order drain
    st(32'h0, 32'hA0); st(32'h4, 32'hA1); st(32'h8, 32'hA2); st(32'hC, 32'hA3);
    st(32'h10, 32'hA4);                    // held off while full
    idle(6, 1'b1);

    // Merge behind the in-flight head
    st(32'h20, 32'h11); idle(2, 1'b0);
    st(32'h40, 32'h22); st(32'h40, 32'h33);
    idle(1, 1'b0); idle(4, 1'b1);

    // Store to the in-flight head allocates a new entry
    st(32'h20, 32'h11); idle(2, 1'b0);
    st(32'h22, 32'h55);
    idle(5, 1'b1);

    // Line conflict
    st(32'h1004, 32'h77);
    g_ra = 32'h101C; idle(2, 1'b0);
    g_ra = 32'h1020; idle(1, 1'b0);
    g_ra = 32'h101C; idle(1, 1'b1); idle(2, 1'b0);

    // Reset mid-transfer followed by a stray ack
    st(32'h100, 32'h1); st(32'h104, 32'h2); st(32'h108, 32'h3);
    idle(2, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, g_ra);
    idle(3, 1'b1);

    // Randomized traffic over a small address window to provoke merges
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 250) == 0, $urandom % 2,
          32'($urandom_range(0, 63)), $urandom,
          ($urandom % 3) == 0, 32'($urandom_range(0, 127)));
    end
    idle(12, 1'b1);
    @(negedge clk); #3;
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
